// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer advanced once per rising edge of a slow tick.
// Optional return stack (CALL/RET, stk_err, stk_level) built when PC_STACK_EN is defined.
module pc_seq #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VEC   = '0,
    parameter int               STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] target,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pc,
    output logic             stepped,
    output logic             stk_err,
    output logic [4:0]       stk_level
);

    typedef enum logic [2:0] {
        OP_INC  = 3'b000,
        OP_HOLD = 3'b001,
        OP_JMP  = 3'b010,
        OP_BR   = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_e;

    logic             s1_q, s2_q, s3_q;
    logic             step;
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic             stepped_q;

    // s3 delays s2 so a tick held high yields a single step
    assign step   = s2_q & ~s3_q;
    assign pc_inc = pc_q + WIDTH'(1);

`ifdef PC_STACK_EN
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [4:0]       level_q, level_d;
    logic             err_q, err_d, err_set;
    logic             push, pop, full, empty;
    logic [AW-1:0]    wr_idx, rd_idx;

    assign full   = (level_q == 5'(STACK_DEPTH));
    assign empty  = (level_q == 5'd0);
    assign wr_idx = level_q[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);
`endif

    always_comb begin
        pc_d = pc_q;
`ifdef PC_STACK_EN
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
`endif
        if (step) begin
            case (op_e'(op))
                OP_HOLD: pc_d = pc_q;
                OP_JMP:  pc_d = target;
                OP_BR:   pc_d = pc_q + target;
`ifdef PC_STACK_EN
                OP_CALL: begin
                    if (!full) begin
                        push = 1'b1;
                        pc_d = target;
                    end else begin
                        pc_d    = pc_inc;
                        err_set = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!empty) begin
                        pop  = 1'b1;
                        pc_d = stack_q[rd_idx];
                    end else begin
                        pc_d    = pc_inc;
                        err_set = 1'b1;
                    end
                end
`else
                OP_CALL: pc_d = target;
                OP_RET:  pc_d = pc_inc;
`endif
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            pc_q      <= RESET_VEC;
            stepped_q <= 1'b0;
        end else begin
            s1_q      <= tick_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pc_q      <= pc_d;
            stepped_q <= step;
        end
    end

`ifdef PC_STACK_EN
    // Set beats clear when both land on the same edge
    always_comb begin
        level_d = level_q;
        if (push)
            level_d = level_q + 5'd1;
        else if (pop)
            level_d = level_q - 5'd1;
        err_d = err_set | (err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Entries need no reset: level_q alone decides which are valid
    always_ff @(posedge clk) begin
        if (push)
            stack_q[wr_idx] <= pc_inc;
    end

    assign stk_err   = err_q;
    assign stk_level = level_q;
`else
    logic unused_clr;
    localparam int unused_depth = STACK_DEPTH;
    assign unused_clr = clr_err;
    assign stk_err    = 1'b0;
    assign stk_level  = 5'd0;
`endif

    assign pc      = pc_q;
    assign stepped = stepped_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: randomized scoreboard bench for pc_seq against a queue-based reference model.
module tb_pc_seq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] target = 16'd0;
    logic        clr_err = 1'b0;
    logic [15:0] pc;
    logic        stepped;
    logic        stk_err;
    logic [4:0]  stk_level;

    pc_seq #(.WIDTH(16), .RESET_VEC(16'h0000), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst_n), .tick_in(tick_in), .op(op), .target(target),
        .clr_err(clr_err), .pc(pc), .stepped(stepped), .stk_err(stk_err),
        .stk_level(stk_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        err;
        logic [4:0]  lvl;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_pc;
    logic [15:0] ref_stk[$];
    logic        ref_err;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what one step does, from the architectural rules
    task automatic model_step(input logic [2:0] o, input logic [15:0] t);
        case (o)
            3'd1: ;
            3'd2: ref_pc = t;
            3'd3: ref_pc = ref_pc + t;
            3'd4: begin
`ifdef PC_STACK_EN
                if (ref_stk.size() < DEPTH) begin
                    ref_stk.push_back(ref_pc + 16'd1);
                    ref_pc = t;
                end else begin
                    ref_pc  = ref_pc + 16'd1;
                    ref_err = 1'b1;
                end
`else
                ref_pc = t;
`endif
            end
            3'd5: begin
`ifdef PC_STACK_EN
                if (ref_stk.size() > 0) begin
                    ref_pc = ref_stk.pop_back();
                end else begin
                    ref_pc  = ref_pc + 16'd1;
                    ref_err = 1'b1;
                end
`else
                ref_pc = ref_pc + 16'd1;
`endif
            end
            default: ref_pc = ref_pc + 16'd1;
        endcase
    endtask

    task automatic model_reset();
        ref_pc  = 16'h0000;
        ref_err = 1'b0;
        ref_stk.delete();
    endtask

    // Called just after a negedge; PC must update 3 posedges later
    task automatic do_tick(input logic [2:0] o, input logic [15:0] t, input int hi, input int lo);
        exp_t e;
        op      = o;
        target  = t;
        tick_in = 1'b1;
        model_step(o, t);
        e.pc  = ref_pc;
        e.err = ref_err;
        e.lvl = 5'(ref_stk.size());
        e.cyc = cyc + 3;
        sb.push_back(e);
        repeat (hi) @(negedge clk);
        tick_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        ref_err = 1'b0;
        check("clr_err", int'(stk_err), 0);
    endtask

    // Monitor: every stepped pulse consumes one expectation
    always @(negedge clk) begin
        if (rst_n && stepped) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_step: stepped=1 with no step expected at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pc", int'(pc), int'(e.pc));
                check("stk_err", int'(stk_err), int'(e.err));
                check("stk_level", int'(stk_level), int'(e.lvl));
                check("step_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pc", int'(pc), 0);
        check("rst_stepped", int'(stepped), 0);
        check("rst_err", int'(stk_err), 0);
        check("rst_level", int'(stk_level), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Divide-by-4 tick, INC
        repeat (4) do_tick(3'd0, 16'h0000, 2, 2);

        // Wrap, branch, jump
        do_tick(3'd2, 16'hFFFF, 2, 2);
        do_tick(3'd0, 16'h0000, 2, 2);
        do_tick(3'd2, 16'h0001, 2, 2);
        do_tick(3'd3, 16'hFFFE, 2, 2);
        do_tick(3'd2, 16'h1234, 2, 2);
        do_tick(3'd1, 16'hABCD, 2, 2);

        // Nested CALL/RET
        do_tick(3'd2, 16'h0010, 2, 2);
        do_tick(3'd4, 16'h0100, 2, 2);
        do_tick(3'd4, 16'h0200, 2, 2);
        do_tick(3'd5, 16'h0000, 2, 2);
        do_tick(3'd5, 16'h0000, 2, 2);
        check("nest_pc", int'(pc), int'(ref_pc));

        // Overflow then underflow, then clear
        for (int i = 0; i < 5; i++) do_tick(3'd4, 16'h0400 + 16'(i * 16), 2, 2);
        for (int i = 0; i < 5; i++) do_tick(3'd5, 16'h0000, 2, 2);
`ifdef PC_STACK_EN
        check("underflow_err", int'(stk_err), 1);
`endif
        pulse_clr();

        // Held tick: one step only
        do_tick(3'd0, 16'h0000, 20, 3);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            logic [2:0]  o;
            logic [15:0] t;
            o = 3'($urandom_range(0, 7));
            t = 16'($urandom);
            if (o == 3'd3 && $urandom_range(0, 1) == 1) t = 16'($urandom_range(0, 15)) - 16'd8;
            do_tick(o, t, $urandom_range(1, 3), $urandom_range(2, 4));
            if ($urandom_range(0, 9) == 0) pulse_clr();
        end

        // Reset mid-CALL: step is live when reset drops
        do_tick(3'd2, 16'h0050, 2, 2);
        do_tick(3'd4, 16'h0070, 2, 2);
        op      = 3'd4;
        target  = 16'h0700;
        tick_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", int'(pc), 0);
        check("async_rst_level", int'(stk_level), 0);
        check("async_rst_err", int'(stk_err), 0);
        model_reset();
        tick_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("no_step_after_abort", int'(pc), 0);
        do_tick(3'd0, 16'h0000, 2, 2);
        do_tick(3'd5, 16'h0000, 2, 2);

        repeat (6) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
